// File: rtl/ctrl_pkg.sv
// Shared control types for the DE/EX decode and control pipeline: opcodes,
// ALU/immediate/branch/writeback encodings, control bundles and MDU states.
package ctrl_pkg;

    localparam int RA_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } aluop_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_CSR = 2'b11
    } sel_wb_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    typedef enum logic [2:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
    } br_type_e;

    // memory access type carries the load/store func3 unchanged
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        MDU_RUN, MDU_BUSY, MDU_DONE
    } mdu_state_e;

    typedef struct packed {
        logic      sel_opr_a;
        logic      sel_opr_b;
        aluop_e    aluop;
        imm_type_e imm_type;
        br_type_e  br_type;
        logic      sel_pc;
        logic      csr_rd;
        logic      is_mret;
        logic [2:0] mdu_op;
    } ctrl_ex_t;

    typedef struct packed {
        logic            valid;
        logic            rf_en;
        logic            rd_en;
        logic            wr_en;
        sel_wb_e         sel_wb;
        logic [2:0]      mem_type;
        logic            csr_wr;
        logic            is_mdu;
        logic [RA_W-1:0] rd_addr;
    } ctrl_wb_t;

    function automatic aluop_e alu_from_f3(input logic [2:0] f3, input logic alt);
        aluop_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic br_type_e br_from_f3(input logic [2:0] f3);
        br_type_e br;
        case (f3)
            3'b000:  br = BR_EQ;
            3'b001:  br = BR_NE;
            3'b100:  br = BR_LT;
            3'b101:  br = BR_GE;
            3'b110:  br = BR_LTU;
            3'b111:  br = BR_GEU;
            default: br = BR_NONE;
        endcase
        return br;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32 decode of the DE/EX instruction into EX and WB
// control bundles plus an illegal flag. MDU_EN adds the M-extension (func7=0x01).
module instr_decoder
    import ctrl_pkg::*;
(
    input  logic            instr_valid,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [RA_W-1:0] rd_addr,
    input  logic            br_taken,
    output ctrl_ex_t        ex_ctrl,
    output ctrl_wb_t        wb_ctrl,
    output logic            illegal_instr
);

    always_comb begin
        ex_ctrl       = '0;
        wb_ctrl       = '0;
        illegal_instr = 1'b0;
        if (instr_valid) begin
            wb_ctrl.valid   = 1'b1;
            wb_ctrl.rd_addr = rd_addr;
            case (opcode)
                OPC_LUI: begin
                    ex_ctrl.sel_opr_b = 1'b1;
                    ex_ctrl.aluop     = ALU_LUI;
                    ex_ctrl.imm_type  = IMM_U;
                    wb_ctrl.rf_en     = 1'b1;
                end
                OPC_AUIPC: begin
                    ex_ctrl.sel_opr_a = 1'b1;
                    ex_ctrl.sel_opr_b = 1'b1;
                    ex_ctrl.imm_type  = IMM_U;
                    wb_ctrl.rf_en     = 1'b1;
                end
                OPC_JAL: begin
                    ex_ctrl.sel_opr_a = 1'b1;
                    ex_ctrl.sel_opr_b = 1'b1;
                    ex_ctrl.imm_type  = IMM_J;
                    ex_ctrl.sel_pc    = 1'b1;
                    wb_ctrl.rf_en     = 1'b1;
                    wb_ctrl.sel_wb    = WB_PC4;
                end
                OPC_JALR: begin
                    ex_ctrl.sel_opr_b = 1'b1;
                    ex_ctrl.imm_type  = IMM_I;
                    ex_ctrl.sel_pc    = 1'b1;
                    wb_ctrl.rf_en     = 1'b1;
                    wb_ctrl.sel_wb    = WB_PC4;
                end
                OPC_BRANCH: begin
                    // ALU forms the target; the comparator result arrives separately
                    ex_ctrl.sel_opr_a = 1'b1;
                    ex_ctrl.sel_opr_b = 1'b1;
                    ex_ctrl.imm_type  = IMM_B;
                    ex_ctrl.br_type   = br_from_f3(func3);
                    ex_ctrl.sel_pc    = br_taken;
                    illegal_instr     = (func3[2:1] == 2'b01);
                end
                OPC_LOAD: begin
                    ex_ctrl.sel_opr_b = 1'b1;
                    ex_ctrl.imm_type  = IMM_I;
                    wb_ctrl.rf_en     = 1'b1;
                    wb_ctrl.rd_en     = 1'b1;
                    wb_ctrl.sel_wb    = WB_MEM;
                    wb_ctrl.mem_type  = func3;
                    illegal_instr     = (func3 == 3'b011) || (func3[2:1] == 2'b11);
                end
                OPC_STORE: begin
                    ex_ctrl.sel_opr_b = 1'b1;
                    ex_ctrl.imm_type  = IMM_S;
                    wb_ctrl.wr_en     = 1'b1;
                    wb_ctrl.mem_type  = func3;
                    illegal_instr     = (func3 > MEM_W);
                end
                OPC_OP_IMM: begin
                    ex_ctrl.sel_opr_b = 1'b1;
                    ex_ctrl.imm_type  = IMM_I;
                    ex_ctrl.aluop     = alu_from_f3(func3, func7[5] & (func3 == 3'b101));
                    wb_ctrl.rf_en     = 1'b1;
                end
                OPC_OP: begin
                    wb_ctrl.rf_en = 1'b1;
                    if ((func7 == 7'h00) ||
                        ((func7 == 7'h20) && ((func3 == 3'b000) || (func3 == 3'b101))))
                        ex_ctrl.aluop = alu_from_f3(func3, func7[5]);
`ifdef MDU_EN
                    else if (func7 == 7'h01) begin
                        wb_ctrl.is_mdu = 1'b1;
                        ex_ctrl.mdu_op = func3;
                    end
`endif
                    else
                        illegal_instr = 1'b1;
                end
                OPC_SYSTEM: begin
                    if (func3 != 3'b000) begin
                        ex_ctrl.csr_rd   = 1'b1;
                        ex_ctrl.imm_type = IMM_I;
                        wb_ctrl.csr_wr   = 1'b1;
                        wb_ctrl.rf_en    = 1'b1;
                        wb_ctrl.sel_wb   = WB_CSR;
                    end else begin
                        ex_ctrl.is_mret = 1'b1;
                        ex_ctrl.sel_pc  = 1'b1;
                    end
                end
                OPC_FENCE: begin
                end
                default: illegal_instr = 1'b1;
            endcase
            if (illegal_instr) begin
                ex_ctrl = '0;
                wb_ctrl = '0;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// DE/EX control unit: decode, WB control register, WB->EX forwarding, IF flush,
// MDU stall sequencing and instret. Define MDU_EN to enable multiply/divide.
//   state    | meaning
//   MDU_RUN  | normal issue; a valid MDU op launches and stalls
//   MDU_BUSY | MDU computing, pipeline held, cnt counts down
//   MDU_DONE | result ready, instruction advances into WB
module pipeline_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              br_taken,
    output ctrl_ex_t          ex_ctrl,
    output ctrl_wb_t          wb_ctrl,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic              stall,
    output logic              flush_if,
    output logic              illegal_instr,
    output logic              mdu_start,
    output logic [CNT_W-1:0]  instret
);

    localparam int CW = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;

    ctrl_wb_t        wb_dec;
    logic [RA_W-1:0] rs1_ext, rs2_ext, rd_ext;
    mdu_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mdu_req;

    assign rs1_ext = RA_W'(rs1_addr);
    assign rs2_ext = RA_W'(rs2_addr);
    assign rd_ext  = RA_W'(rd_addr);

    instr_decoder u_dec (
        .instr_valid   (instr_valid),
        .opcode        (opcode),
        .func3         (func3),
        .func7         (func7),
        .rd_addr       (rd_ext),
        .br_taken      (br_taken),
        .ex_ctrl       (ex_ctrl),
        .wb_ctrl       (wb_dec),
        .illegal_instr (illegal_instr)
    );

    // gating with rst_n keeps stall/mdu_start low while reset is held
`ifdef MDU_EN
    assign mdu_req = rst_n & wb_dec.valid & wb_dec.is_mdu;
`else
    assign mdu_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        mdu_start = 1'b0;
        case (state_q)
            MDU_RUN: begin
                if (mdu_req) begin
                    stall     = 1'b1;
                    mdu_start = 1'b1;
                    cnt_d     = CW'(MDU_LATENCY - 1);
                    state_d   = (MDU_LATENCY == 1) ? MDU_DONE : MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1))
                    state_d = MDU_DONE;
            end
            MDU_DONE: state_d = MDU_RUN;
            default:  state_d = MDU_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ctrl <= '0;
            instret <= '0;
        end else begin
            wb_ctrl <= stall ? '0 : wb_dec;
            if (!stall && wb_dec.valid)
                instret <= instret + 1'b1;
        end
    end

    assign fwd_a = wb_ctrl.valid & wb_ctrl.rf_en & (wb_ctrl.rd_addr != '0) &
                   (wb_ctrl.rd_addr == rs1_ext);
    assign fwd_b = wb_ctrl.valid & wb_ctrl.rf_en & (wb_ctrl.rd_addr != '0) &
                   (wb_ctrl.rd_addr == rs2_ext);

    assign flush_if = ex_ctrl.sel_pc & ~stall;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Scoreboard bench for pipeline_ctrl_unit (4-bit instret so wrap is reachable).
module tb_pipeline_ctrl_unit;
    import ctrl_pkg::*;

    localparam int LAT = 4;
`ifdef MDU_EN
    localparam bit MDU_ON = 1'b1;
`else
    localparam bit MDU_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, br_taken;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    ctrl_ex_t    ex_ctrl;
    ctrl_wb_t    wb_ctrl;
    logic        fwd_a, fwd_b, stall, flush_if, illegal_instr, mdu_start;
    logic [3:0]  instret;

    int          n_chk = 0;
    int          n_err = 0;
    logic [3:0]  exp_cnt;
    logic [6:0]  sb_q[$];

    // e = {illegal, sel_pc, fwd_a, fwd_b, is_mdu_op, wb_valid, wb_rf_en}
    typedef struct {
        logic       v;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rs1, rs2, rd;
        logic       br;
        logic [6:0] e;
    } stim_t;

    always #5 clk = ~clk;

    pipeline_ctrl_unit #(.REG_AW(5), .MDU_LATENCY(LAT), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .opcode        (opcode),
        .func3         (func3),
        .func7         (func7),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rd_addr       (rd_addr),
        .br_taken      (br_taken),
        .ex_ctrl       (ex_ctrl),
        .wb_ctrl       (wb_ctrl),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall         (stall),
        .flush_if      (flush_if),
        .illegal_instr (illegal_instr),
        .mdu_start     (mdu_start),
        .instret       (instret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic stim_t mk(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic br, input logic [6:0] e);
        stim_t s;
        s.v = v; s.opc = opc; s.f3 = f3; s.f7 = f7;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.br = br; s.e = e;
        return s;
    endfunction

    // called at posedge+1; returns at posedge+1 after the instruction enters WB
    task automatic run(input string tag, input stim_t s);
        int         ns;
        logic [6:0] exp_wb, got_wb;
        ns = s.e[2] ? LAT : 0;
        instr_valid = s.v;   opcode   = s.opc; func3    = s.f3; func7 = s.f7;
        rs1_addr    = s.rs1; rs2_addr = s.rs2; rd_addr  = s.rd; br_taken = s.br;
        for (int c = 0; c <= ns; c++) begin
            #3;
            chk({tag, ".stall"}, 32'(stall), 32'(c < ns));
            chk({tag, ".mdu_start"}, 32'(mdu_start), 32'(c == 0 && ns > 0));
            if (c == ns) begin
                chk({tag, ".illegal"}, 32'(illegal_instr), 32'(s.e[6]));
                chk({tag, ".sel_pc"}, 32'(ex_ctrl.sel_pc), 32'(s.e[5]));
                chk({tag, ".flush_if"}, 32'(flush_if), 32'(s.e[5]));
                chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(s.e[4]));
                chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(s.e[3]));
                sb_q.push_back({s.e[1], s.e[0], s.e[1] ? s.rd : 5'd0});
            end else begin
                sb_q.push_back(7'd0);
            end
            @(posedge clk); #1;
            chk({tag, ".sb_depth"}, 32'(sb_q.size()), 32'd1);
            if (sb_q.size() != 0) begin
                exp_wb = sb_q.pop_front();
                got_wb = {wb_ctrl.valid, wb_ctrl.rf_en, wb_ctrl.rd_addr};
                chk({tag, ".wb"}, 32'(got_wb), 32'(exp_wb));
                if (exp_wb[6]) exp_cnt = exp_cnt + 4'd1;
                chk({tag, ".instret"}, 32'(instret), 32'(exp_cnt));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; br_taken = 1'b0;
        opcode = '0; func3 = '0; func7 = '0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
        exp_cnt = '0;
        #2;
        chk("rst.wb_ctrl", 32'(wb_ctrl), 32'd0);
        chk("rst.ex_ctrl", 32'(ex_ctrl), 32'd0);
        chk("rst.instret", 32'(instret), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.mdu_start", 32'(mdu_start), 32'd0);
        chk("rst.illegal", 32'(illegal_instr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run("add",      mk(1, 7'b0110011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 0, 7'b0000011));
        run("sub",      mk(1, 7'b0110011, 3'b000, 7'h20, 5'd3, 5'd1, 5'd4, 0, 7'b0010011));
        run("beq_t",    mk(1, 7'b1100011, 3'b000, 7'h00, 5'd4, 5'd0, 5'd0, 1, 7'b0110010));
        run("beq_nt",   mk(1, 7'b1100011, 3'b000, 7'h00, 5'd5, 5'd6, 5'd0, 0, 7'b0000010));
        run("opc_7f",   mk(1, 7'h7F,      3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 0, 7'b1000000));
        run("mul",      mk(1, 7'b0110011, 3'b000, 7'h01, 5'd1, 5'd2, 5'd9, 0,
                           MDU_ON ? 7'b0000111 : 7'b1000000));
        run("addi_x0",  mk(1, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 0, 7'b0000011));
        run("add_x5",   mk(1, 7'b0110011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd5, 0, 7'b0000011));
        run("lw",       mk(1, 7'b0000011, 3'b010, 7'h00, 5'd5, 5'd0, 5'd6, 0, 7'b0010011));
        run("add_ld",   mk(1, 7'b0110011, 3'b000, 7'h00, 5'd6, 5'd6, 5'd7, 0, 7'b0011011));
        run("jal",      mk(1, 7'b1101111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 0, 7'b0100011));
        run("bubble",   mk(0, 7'b0110011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 0, 7'b0000000));
        run("ld_f3_3",  mk(1, 7'b0000011, 3'b011, 7'h00, 5'd0, 5'd0, 5'd0, 0, 7'b1000000));
        run("st_f3_3",  mk(1, 7'b0100011, 3'b011, 7'h00, 5'd0, 5'd0, 5'd0, 0, 7'b1000000));
        run("br_f3_2",  mk(1, 7'b1100011, 3'b010, 7'h00, 5'd0, 5'd0, 5'd0, 1, 7'b1000000));
        run("op_f7_20", mk(1, 7'b0110011, 3'b001, 7'h20, 5'd0, 5'd0, 5'd0, 0, 7'b1000000));
        run("sll",      mk(1, 7'b0110011, 3'b001, 7'h00, 5'd1, 5'd3, 5'd2, 0, 7'b0000011));
        run("csr",      mk(1, 7'b1110011, 3'b001, 7'h00, 5'd2, 5'd0, 5'd8, 0, 7'b0010011));
        run("mret",     mk(1, 7'b1110011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 0, 7'b0100010));
        run("sw",       mk(1, 7'b0100011, 3'b010, 7'h00, 5'd8, 5'd9, 5'd0, 0, 7'b0000010));

        // reset in the second BUSY cycle of an MDU op (plain illegal op without MDU_EN)
        instr_valid = 1'b1; opcode = 7'b0110011; func3 = 3'b000; func7 = 7'h01;
        rs1_addr = 5'd1; rs2_addr = 5'd2; rd_addr = 5'd9; br_taken = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid.busy_stall", 32'(stall), 32'(MDU_ON));
        rst_n = 1'b0;
        #1;
        chk("mid.stall", 32'(stall), 32'd0);
        chk("mid.mdu_start", 32'(mdu_start), 32'd0);
        chk("mid.wb_ctrl", 32'(wb_ctrl), 32'd0);
        chk("mid.instret", 32'(instret), 32'd0);
        instr_valid = 1'b0;
        exp_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel.stall", 32'(stall), 32'd0);
        chk("rel.wb_valid", 32'(wb_ctrl.valid), 32'd0);

        for (int i = 0; i < 17; i++)
            run("wrap_add", mk(1, 7'b0110011, 3'b000, 7'h00, 5'd11, 5'd12, 5'd10, 0, 7'b0000011));
        chk("wrap.final", 32'(instret), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
